// File: rtl/hpm_mcycle_ctr.sv
// Machine-mode cycle counter (mcycle/mcycleh) with mcountinhibit.CY hold and 64-bit wrap pulse.
// Define HPM_MCYCLE_WR_EN to add the CSR write ports (wr_lo, wr_hi, wr_data).
module hpm_mcycle_ctr #(
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inhibit,
`ifdef HPM_MCYCLE_WR_EN
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
`endif
  output logic [31:0] clk_cnt,
  output logic [31:0] clk_cnt_h,
  output logic        ovf
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;
  logic        ovf_q;
  logic        ovf_d;
  logic [64:0] inc_sum;

  // Next-state: write beats inhibit beats increment; only a full 64-bit carry-out pulses ovf.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    inc_sum = {1'b0, cnt_q} + 65'd1;
`ifdef HPM_MCYCLE_WR_EN
    if (wr_lo || wr_hi) begin
      if (wr_lo) begin
        cnt_d[31:0] = wr_data;
      end else begin
        cnt_d[31:0] = cnt_q[31:0];
      end
      if (wr_hi) begin
        cnt_d[63:32] = wr_data;
      end else begin
        cnt_d[63:32] = cnt_q[63:32];
      end
    end else
`endif
    if (inhibit) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = inc_sum[63:0];
      ovf_d = inc_sum[64];
    end
  end

  // State register with synchronous active-low reset overriding all other inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= RESET_VALUE;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign clk_cnt   = cnt_q[31:0];
  assign clk_cnt_h = cnt_q[63:32];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_hpm_mcycle_ctr.sv
// Scoreboard bench for hpm_mcycle_ctr: default-reset and overridden-reset instances driven in lockstep.
// Write-port scenarios are exercised only when HPM_MCYCLE_WR_EN is defined.
module tb_hpm_mcycle_ctr;

  localparam logic [63:0] RV_B = 64'h0000_0001_0000_0000;

  logic        clk;
  logic        rst_n;
  logic        inhibit;
`ifdef HPM_MCYCLE_WR_EN
  logic        wr_lo;
  logic        wr_hi;
  logic [31:0] wr_data;
`endif
  logic [31:0] cnt_a, cnt_h_a, cnt_b, cnt_h_b;
  logic        ovf_a, ovf_b;

  typedef struct packed {
    logic [63:0] a;
    logic        a_ovf;
    logic [63:0] b;
    logic        b_ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] ma    = 64'd0;
  logic [63:0] mb    = 64'd0;

  hpm_mcycle_ctr dut_a (
    .clk(clk), .rst_n(rst_n), .inhibit(inhibit),
`ifdef HPM_MCYCLE_WR_EN
    .wr_lo(wr_lo), .wr_hi(wr_hi), .wr_data(wr_data),
`endif
    .clk_cnt(cnt_a), .clk_cnt_h(cnt_h_a), .ovf(ovf_a)
  );

  hpm_mcycle_ctr #(.RESET_VALUE(RV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .inhibit(inhibit),
`ifdef HPM_MCYCLE_WR_EN
    .wr_lo(wr_lo), .wr_hi(wr_hi), .wr_data(wr_data),
`endif
    .clk_cnt(cnt_b), .clk_cnt_h(cnt_h_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what the counter holds after one edge, from the architectural rules.
  function automatic logic [64:0] model_next(logic [63:0] m, logic [63:0] rv, logic r,
                                             logic inh, logic wl, logic wh, logic [31:0] wd);
    logic [63:0] n;
    if (!r) return {1'b0, rv};
`ifdef HPM_MCYCLE_WR_EN
    if (wl || wh) begin
      n = m;
      if (wl) n[31:0]  = wd;
      if (wh) n[63:32] = wd;
      return {1'b0, n};
    end
`endif
    if (inh) return {1'b0, m};
    if (m == 64'hFFFF_FFFF_FFFF_FFFF) return {1'b1, 64'd0};
    n = m + 64'd1;
    return {1'b0, n};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic step(logic r, logic inh, logic wl, logic wh, logic [31:0] wd);
    logic [64:0] na, nb;
    exp_t e;
    @(negedge clk);
    rst_n   = r;
    inhibit = inh;
`ifdef HPM_MCYCLE_WR_EN
    wr_lo   = wl;
    wr_hi   = wh;
    wr_data = wd;
`endif
    na = model_next(ma, 64'd0, r, inh, wl, wh, wd);
    nb = model_next(mb, RV_B,  r, inh, wl, wh, wd);
    ma = na[63:0];
    mb = nb[63:0];
    e.a = ma; e.a_ovf = na[64];
    e.b = mb; e.b_ovf = nb[64];
    exp_q.push_back(e);
  endtask

  // Monitor: just after every rising edge, compare outputs to the oldest pending expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cnt_a",   {32'd0, cnt_a},   {32'd0, e.a[31:0]});
      chk("cnt_h_a", {32'd0, cnt_h_a}, {32'd0, e.a[63:32]});
      chk("ovf_a",   {63'd0, ovf_a},   {63'd0, e.a_ovf});
      chk("cnt_b",   {32'd0, cnt_b},   {32'd0, e.b[31:0]});
      chk("cnt_h_b", {32'd0, cnt_h_b}, {32'd0, e.b[63:32]});
      chk("ovf_b",   {63'd0, ovf_b},   {63'd0, e.b_ovf});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        r, inh, wl, wh;
    logic [31:0] wd;
    rst_n   = 1'b0;
    inhibit = 1'b0;
`ifdef HPM_MCYCLE_WR_EN
    wr_lo   = 1'b0;
    wr_hi   = 1'b0;
    wr_data = 32'd0;
`endif
    // Reset for 3 cycles, then free run and an inhibit window at 10.
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

`ifdef HPM_MCYCLE_WR_EN
    // Low-word carry into the high word without ovf.
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    // All-ones: held under inhibit without ovf, then wraps with a single pulse.
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
`endif

    // Reset mid-count at 1000 alongside a write strobe.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (1000) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) != 0);
      inh = ($urandom_range(0, 3) == 0);
      wl  = ($urandom_range(0, 15) == 0);
      wh  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       wd = 32'hFFFF_FFFF;
        1:       wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: wd = $urandom;
      endcase
      step(r, inh, wl, wh, wd);
    end

    @(negedge clk);
    @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpm_mcycle_ctr.md
Name: hpm_mcycle_ctr

Overview:
- RISC-V machine-mode cycle counter (mcycle/mcycleh) for the hart's HPM block.
- Free-running 64-bit count of clk cycles since reset, with mcountinhibit.CY hold and a wrap pulse.
- Instantiated by the CSR unit. The CSR unit muxes the low word onto its read port for CSR address 0xB00 and the high word for 0xB80.

Parameters:
- RESET_VALUE, 64'd0, value loaded into the 64-bit counter on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- inhibit  input  1  mcountinhibit.CY; 1 holds the count.
- clk_cnt  output  32  counter bits [31:0] (mcycle).
- clk_cnt_h  output  32  counter bits [63:32] (mcycleh).
- ovf  output  1  one-cycle pulse on 64-bit wrap.
- wr_lo  input  1  write strobe for low word (only with HPM_MCYCLE_WR_EN).
- wr_hi  input  1  write strobe for high word (only with HPM_MCYCLE_WR_EN).
- wr_data  input  32  write data (only with HPM_MCYCLE_WR_EN).

Behaviour:
- State: one 64-bit register cnt and one 1-bit register ovf. Outputs are driven directly from registers; no combinational path from any input to any output.
- Reset: rising clk edge with rst_n=0 sets cnt<=RESET_VALUE and ovf<=0. Reset has no asynchronous effect. Reset overrides every other input, including write strobes.
- After reset release: at the first edge with rst_n=1, the pre-edge output is RESET_VALUE. The count then advances by 1 per edge, so clk_cnt reads 0,1,2,... on consecutive cycles for RESET_VALUE=0.
- Priority per edge (rst_n=1), highest first:
  - reset
  - write (macro only)
  - inhibit hold
  - increment
- Increment: cnt<=cnt+1 modulo 2^64. Carry from bit 31 propagates into bit 32 in the same cycle, so there is no torn-read window between the halves.
- Wrap: when an increment takes cnt from 64'hFFFF_FFFF_FFFF_FFFF to 0, ovf<=1 for exactly one cycle. Otherwise ovf<=0.
  - A write never raises ovf.
  - Holding at all-ones under inhibit never raises ovf.
- Inhibit: inhibit=1 leaves cnt unchanged and sets ovf<=0. Counting resumes on the first edge with inhibit=0.
- Low-word wrap (32'hFFFF_FFFF to 0) only increments clk_cnt_h. It does not pulse ovf.

Optional Feature:
- Macro HPM_MCYCLE_WR_EN.
- Defined: ports wr_lo, wr_hi and wr_data exist.
  - wr_lo=1 loads cnt[31:0]<=wr_data and leaves cnt[63:32] unchanged, with no increment that cycle.
  - wr_hi=1 loads cnt[63:32]<=wr_data and leaves the low half unchanged, with no increment that cycle.
  - Both strobes in the same cycle load both halves with wr_data.
  - Writes win over inhibit and increment. The written value is visible on the outputs the following cycle, and counting continues from it.
- Not defined: the three ports are absent and the counter is read-only, with no write logic synthesized.

Test Plan:
- Hold rst_n=0 for 3 cycles, then release -> clk_cnt=0 and clk_cnt_h=0 during reset; clk_cnt=5 five cycles after release; ovf stays 0 throughout.
- Counting with inhibit=1 for 4 cycles, then 0 -> count frozen at its value (e.g. 10) for 4 cycles, then 11,12,...
- With macro: wr_lo with 32'hFFFF_FFFE, wr_hi with 0 -> after write 0000_0000_FFFF_FFFE, then FFFF_FFFF, then clk_cnt=0 and clk_cnt_h=1 with ovf=0.
- With macro: write both halves to 32'hFFFF_FFFF -> the next increment gives cnt=0 with ovf=1 for exactly one cycle; the write cycle itself shows no ovf.
- Assert rst_n=0 mid-count at value 1000 together with wr_lo=1 -> cnt=RESET_VALUE (0) on the next cycle and the write is ignored.
- Override RESET_VALUE=64'h0000_0001_0000_0000 -> after reset clk_cnt=0 and clk_cnt_h=1, and counting proceeds from there.
